// File: rtl/edge_morph_if.sv
// Binary edge-pixel stream: detector-side input (pre_*) and display-side output (post_*).
interface edge_morph_if;
  logic pre_vs;
  logic pre_de;
  logic pre_bit;
  logic post_vs;
  logic post_de;
  logic post_bit;

  modport master (output pre_vs, pre_de, pre_bit, input post_vs, post_de, post_bit);
  modport slave  (input pre_vs, pre_de, pre_bit, output post_vs, post_de, post_bit);
endinterface

// File: rtl/edge_morph.sv
// Binary 3x3 morphology (erode / dilate / majority) on the edge-detector bit stream.
// Fixed 3-clock latency for vs/de/bit. Window centre is one row and one column behind
// the incoming pixel. Also reports the number of set output pixels in the previous frame.
module edge_morph #(
  parameter logic [10:0] IMG_HDISP = 11'd1280,
  parameter logic [10:0] IMG_VDISP = 11'd720
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        EN,
  input  logic [1:0]  mode,
  edge_morph_if.slave bus,
  output logic [20:0] edge_count
);

  localparam int AW    = (IMG_HDISP > 11'd1) ? $clog2(IMG_HDISP) : 1;
  localparam int DEPTH = int'(IMG_HDISP);

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_ERODE  = 2'd1,
    MODE_DILATE = 2'd2,
    MODE_MAJ    = 2'd3
  } mode_e;

  mode_e       r_actMode;
  logic        r_vsPrev;
  logic        r_dePrev;
  logic [10:0] r_col;
  logic [10:0] r_row;

  logic        r_lb1 [DEPTH];
  logic        r_lb2 [DEPTH];

  logic        r_s1Vs, r_s1De, r_s1Bit, r_s1Up1, r_s1Up2;
  logic        r_s1Row1, r_s1Row2, r_s1Col1, r_s1Col2;
  logic        r_s2Vs, r_s2De;
  logic        r_s2Row1, r_s2Row2, r_s2Col1, r_s2Col2;
  logic [8:0]  r_win;
  logic        r_s3Vs, r_s3De, r_s3Bit;
  logic        r_s3VsPrev;
  logic [20:0] r_acc;
  logic [20:0] r_edgeCount;

  logic          w_deFall;
  logic          w_vsRise;
  logic          w_colOk;
  logic          w_wrEn;
  logic          w_ident;
  logic [AW-1:0] w_addr;
  logic          w_rd1;
  logic          w_rd2;
  logic [2:0]    w_rowOk;
  logic [8:0]    w_valid;
  logic [8:0]    w_tap;
  logic [3:0]    w_pop;
  logic          w_res;
  logic          w_postRise;
  logic          w_inc;

  // Taps outside the image take the value that leaves the operator unaffected:
  // 1 for erode (AND), 0 for dilate/majority. Line-buffer reads past the line end do the same.
  assign w_deFall = r_dePrev & ~bus.pre_de;
  assign w_vsRise = bus.pre_vs & ~r_vsPrev;
  assign w_colOk  = (r_col < IMG_HDISP);
  assign w_wrEn   = bus.pre_de & w_colOk;
  assign w_ident  = (r_actMode == MODE_ERODE);
  assign w_addr   = r_col[AW-1:0];
  assign w_rd1    = w_colOk ? r_lb1[w_addr] : w_ident;
  assign w_rd2    = w_colOk ? r_lb2[w_addr] : w_ident;

  // Window bit layout: [2:0] column c, [5:3] column c-1, [8:6] column c-2; within a column
  // bit 0 is row r, bit 1 row r-1, bit 2 row r-2.
  assign w_rowOk = {r_s2Row2, r_s2Row1, 1'b1};
  assign w_valid = {w_rowOk & {3{r_s2Col2}}, w_rowOk & {3{r_s2Col1}}, w_rowOk};
  assign w_tap   = (r_win & w_valid) | ({9{w_ident}} & ~w_valid);
  assign w_pop   = 4'($countones(w_tap));

  assign w_postRise = r_s3Vs & ~r_s3VsPrev;
  assign w_inc      = r_s3De & r_s3Bit;

  assign bus.post_vs  = r_s3Vs;
  assign bus.post_de  = r_s3De;
  assign bus.post_bit = r_s3Bit;
  assign edge_count   = r_edgeCount;

  // Row/column position tracking and once-per-frame capture of the operating mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vsPrev  <= 1'b0;
      r_dePrev  <= 1'b0;
      r_col     <= '0;
      r_row     <= '0;
      r_actMode <= MODE_BYPASS;
    end else begin
      r_vsPrev <= bus.pre_vs;
      r_dePrev <= bus.pre_de;
      if (w_vsRise) begin
        r_actMode <= EN ? mode_e'(mode) : MODE_BYPASS;
      end
      if (bus.pre_vs) begin
        r_col <= '0;
        r_row <= '0;
      end else if (w_deFall) begin
        r_col <= '0;
        if (r_row < IMG_VDISP) begin
          r_row <= r_row + 11'd1;
        end
      end else if (bus.pre_de && w_colOk) begin
        r_col <= r_col + 11'd1;
      end
    end
  end

  // Two 1-bit line RAMs, read-before-write: row r-1 moves into the r-2 buffer as row r lands.
  always_ff @(posedge clk) begin
    if (w_wrEn) begin
      r_lb1[w_addr] <= bus.pre_bit;
      r_lb2[w_addr] <= r_lb1[w_addr];
    end
  end

  // Stage 1: capture the new column of taps together with its in-image flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1Vs   <= 1'b0;
      r_s1De   <= 1'b0;
      r_s1Bit  <= 1'b0;
      r_s1Up1  <= 1'b0;
      r_s1Up2  <= 1'b0;
      r_s1Row1 <= 1'b0;
      r_s1Row2 <= 1'b0;
      r_s1Col1 <= 1'b0;
      r_s1Col2 <= 1'b0;
    end else begin
      r_s1Vs   <= bus.pre_vs;
      r_s1De   <= bus.pre_de;
      r_s1Bit  <= bus.pre_bit;
      r_s1Up1  <= w_rd1;
      r_s1Up2  <= w_rd2;
      r_s1Row1 <= (r_row >= 11'd1);
      r_s1Row2 <= (r_row >= 11'd2);
      r_s1Col1 <= (r_col >= 11'd1);
      r_s1Col2 <= (r_col >= 11'd2);
    end
  end

  // Stage 2: shift the 3x3 window on valid pixels only, so de gaps keep columns contiguous.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2Vs   <= 1'b0;
      r_s2De   <= 1'b0;
      r_s2Row1 <= 1'b0;
      r_s2Row2 <= 1'b0;
      r_s2Col1 <= 1'b0;
      r_s2Col2 <= 1'b0;
      r_win    <= '0;
    end else begin
      r_s2Vs   <= r_s1Vs;
      r_s2De   <= r_s1De;
      r_s2Row1 <= r_s1Row1;
      r_s2Row2 <= r_s1Row2;
      r_s2Col1 <= r_s1Col1;
      r_s2Col2 <= r_s1Col2;
      if (r_s1De) begin
        r_win <= {r_win[5:0], r_s1Up2, r_s1Up1, r_s1Bit};
      end
    end
  end

  // Select the morphology result for the active mode; bypass passes the newest pixel through.
  always_comb begin
    w_res = 1'b0;
    case (r_actMode)
      MODE_ERODE:  w_res = &w_tap;
      MODE_DILATE: w_res = |w_tap;
      MODE_MAJ:    w_res = (w_pop >= 4'd5);
      default:     w_res = r_win[0];
    endcase
  end

  // Stage 3: output register; the bit is forced low outside active video.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s3Vs  <= 1'b0;
      r_s3De  <= 1'b0;
      r_s3Bit <= 1'b0;
    end else begin
      r_s3Vs  <= r_s2Vs;
      r_s3De  <= r_s2De;
      r_s3Bit <= r_s2De & w_res;
    end
  end

  // Per-frame set-pixel count: published and restarted on the output vs rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s3VsPrev  <= 1'b0;
      r_acc       <= '0;
      r_edgeCount <= '0;
    end else begin
      r_s3VsPrev <= r_s3Vs;
      if (w_postRise) begin
        r_edgeCount <= r_acc;
        r_acc       <= {20'd0, w_inc};
      end else if (w_inc && (r_acc != 21'h1FFFFF)) begin
        r_acc <= r_acc + 21'd1;
      end
    end
  end

endmodule
